// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : One 32-bit word requester port (req/ack handshake) of dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port word arbiter onto a byte-wide synchronous SRAM, big-endian
//            byte sequencing. Define DMEM_ARB_FIXED_PRI_EN for fixed port-0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [1:0]        grant
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_XFER = 2'd1;
    localparam logic [1:0] c_ST_TAIL = 2'd2;
    localparam logic [1:0] c_ST_ACK  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [1:0]        r_grant;
    logic [31:8]       r_rbuf;
    logic [31:0]       r_m0_rdata;
    logic [31:0]       r_m1_rdata;

    logic              w_pick0;
    logic              w_pick1;
    logic              w_xfer;

`ifdef DMEM_ARB_FIXED_PRI_EN
    assign w_pick1 = m1.req & ~m0.req;
`else
    // r_last_grant = 1 means port 1 owned the previous transaction
    logic              r_last_grant;
    assign w_pick1 = m1.req & (~m0.req | ~r_last_grant);
`endif
    assign w_pick0 = m0.req & ~w_pick1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 2'd0;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_wdata    <= 32'd0;
            r_grant    <= 2'b00;
            r_rbuf     <= 24'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
`ifndef DMEM_ARB_FIXED_PRI_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= 2'd0;
                    if (w_pick0 || w_pick1) begin
                        r_state <= c_ST_XFER;
                        r_grant <= {w_pick1, w_pick0};
                        r_we    <= w_pick1 ? m1.we    : m0.we;
                        r_base  <= w_pick1 ? m1.addr  : m0.addr;
                        r_wdata <= w_pick1 ? m1.wdata : m0.wdata;
                    end
                end
                c_ST_XFER: begin
                    // SRAM read data lags the address by one cycle
                    if (!r_we) begin
                        case (r_cnt)
                            2'd1:    r_rbuf[31:24] <= mem_rdata;
                            2'd2:    r_rbuf[23:16] <= mem_rdata;
                            2'd3:    r_rbuf[15:8]  <= mem_rdata;
                            default: ;
                        endcase
                    end
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= c_ST_TAIL;
                    end
                end
                c_ST_TAIL: begin
                    // Port rdata is loaded here so it is already valid while ack is high
                    if (!r_we) begin
                        if (r_grant[0]) begin
                            r_m0_rdata <= {r_rbuf, mem_rdata};
                        end else begin
                            r_m1_rdata <= {r_rbuf, mem_rdata};
                        end
                    end
                    r_state <= c_ST_ACK;
                end
                c_ST_ACK: begin
`ifndef DMEM_ARB_FIXED_PRI_EN
                    r_last_grant <= r_grant[1];
`endif
                    r_grant <= 2'b00;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_xfer = (r_state == c_ST_XFER);

    always_comb begin
        mem_wdata = 8'h00;
        if (w_xfer) begin
            case (r_cnt)
                2'd0:    mem_wdata = r_wdata[31:24];
                2'd1:    mem_wdata = r_wdata[23:16];
                2'd2:    mem_wdata = r_wdata[15:8];
                default: mem_wdata = r_wdata[7:0];
            endcase
        end
    end

    assign mem_addr = w_xfer ? (r_base + ADDR_W'(r_cnt)) : '0;
    assign mem_we   = w_xfer & r_we;
    assign busy     = (r_state != c_ST_IDLE);
    assign grant    = r_grant;

    assign m0.ack   = (r_state == c_ST_ACK) & r_grant[0];
    assign m1.ack   = (r_state == c_ST_ACK) & r_grant[1];
    assign m0.rdata = r_m0_rdata;
    assign m1.rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a byte SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_ADDR_W = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [1:0]  grant;

    logic        bd_we;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;
    logic [7:0]  sram [0:4095];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_total = 0;
    int both_ack = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(c_ADDR_W)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(c_ADDR_W)) m1_if ();

    dmem_arbiter #(.ADDR_W(c_ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    // Synchronous-read byte SRAM with a backdoor write port for preloading
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        else if (bd_we) sram[bd_addr] <= bd_data;
        mem_rdata <= sram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m0_if.ack || m1_if.ack) ack_total <= ack_total + 1;
        if (m0_if.ack && m1_if.ack) both_ack <= both_ack + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [11:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_if.req = r; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = r; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? m0_if.ack : m1_if.ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    function automatic logic [31:0] word_at(input logic [11:0] a);
        logic [11:0] a1, a2, a3;
        a1 = a + 12'd1;
        a2 = a + 12'd2;
        a3 = a + 12'd3;
        return {sram[a], sram[a1], sram[a2], sram[a3]};
    endfunction

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Full handshake: latency in cycles from the sampling edge to ack, write strobes seen
    task automatic transact(input int p, input logic we, input logic [11:0] a,
                            input logic [31:0] d, output int lat, output int wec,
                            output logic [31:0] rd, output logic [1:0] g);
        @(negedge clk);
        set_req(p, 1'b1, we, a, d);
        lat = 0; wec = 0; g = 2'b00;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) g = grant;
            if (mem_we) wec++;
        end while (!get_ack(p) && lat < 30);
        rd = get_rdata(p);
        @(posedge clk);
        #1 set_req(p, 1'b0, 1'b0, 12'h000, 32'd0);
    endtask

    initial begin
        int lat, wec, t0, ta, n, acks0;
        logic [31:0] rd, who;
        logic [1:0]  g;
        logic [3:0]  exp_who;

        rst = 1'b1;
        bd_we = 1'b0; bd_addr = 12'h000; bd_data = 8'h00;
        set_req(0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_req(1, 1'b0, 1'b0, 12'h000, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {27'd0, busy, grant, mem_we, m0_if.ack, m1_if.ack}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_m0_rdata", m0_if.rdata, 32'd0);
        chk("rst_m1_rdata", m1_if.rdata, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Port 0 write then read back
        transact(0, 1'b1, 12'h010, 32'hDEADBEEF, lat, wec, rd, g);
        chk("wr0_latency", 32'(lat), 32'd6);
        chk("wr0_grant", {30'd0, g}, 32'd1);
        chk("wr0_we_cycles", 32'(wec), 32'd4);
        chk("wr0_bytes", word_at(12'h010), 32'hDEADBEEF);
        transact(0, 1'b0, 12'h010, 32'd0, lat, wec, rd, g);
        chk("rd0_latency", 32'(lat), 32'd6);
        chk("rd0_rdata", rd, 32'hDEADBEEF);
        chk("rd0_we_cycles", 32'(wec), 32'd0);

        // Port 1 write wrapping the top of memory
        transact(1, 1'b1, 12'hFFE, 32'h11223344, lat, wec, rd, g);
        chk("wrap_latency", 32'(lat), 32'd6);
        chk("wrap_grant", {30'd0, g}, 32'd2);
        chk("wrap_bytes", word_at(12'hFFE), 32'h11223344);
        chk("wrap_byte0", {24'd0, sram[0]}, 32'h33);
        transact(1, 1'b0, 12'hFFE, 32'd0, lat, wec, rd, g);
        chk("wrap_rdata", rd, 32'h11223344);

        // A write leaves the port's read register alone
        poke(12'h200, 8'h55); poke(12'h201, 8'h66); poke(12'h202, 8'h77); poke(12'h203, 8'h88);
        transact(0, 1'b0, 12'h200, 32'd0, lat, wec, rd, g);
        chk("keep_read", rd, 32'h55667788);
        transact(0, 1'b1, 12'h200, 32'd0, lat, wec, rd, g);
        chk("keep_after_write", m0_if.rdata, 32'h55667788);
        chk("keep_bytes", word_at(12'h200), 32'd0);

        // Port 1 requests while port 0 is busy
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 12'h010, 32'd0);
        t0 = cyc;
        repeat (2) @(negedge clk);
        set_req(1, 1'b1, 1'b0, 12'hFFE, 32'd0);
        n = 2;
        do begin @(negedge clk); n++; end while (!m0_if.ack && n < 30);
        ta = cyc;
        chk("held_lat0", 32'(ta - t0), 32'd6);
        chk("held_rd0", m0_if.rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1 set_req(0, 1'b0, 1'b0, 12'h000, 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m1_if.ack && n < 30);
        chk("held_gap", 32'(cyc - ta), 32'd7);
        chk("held_rd1", m1_if.rdata, 32'h11223344);
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, 12'h000, 32'd0);

        // Simultaneous back-to-back requests from a fresh reset
`ifdef DMEM_ARB_FIXED_PRI_EN
        exp_who = 4'b0000;
`else
        exp_who = 4'b1010;
`endif
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 12'h010, 32'd0);
        set_req(1, 1'b1, 1'b0, 12'hFFE, 32'd0);
        ta = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(m0_if.ack || m1_if.ack) && n < 30);
            who = m1_if.ack ? 32'd1 : 32'd0;
            chk($sformatf("tie_grant%0d", k), who, {31'd0, exp_who[k]});
            if (k > 0) chk($sformatf("tie_spacing%0d", k), 32'(cyc - ta), 32'd7);
            ta = cyc;
            @(posedge clk);
            #1;
            if (k == 3) begin
                set_req(0, 1'b0, 1'b0, 12'h000, 32'd0);
                set_req(1, 1'b0, 1'b0, 12'h000, 32'd0);
            end else begin
                set_req(int'(who), 1'b0, 1'b0, 12'h000, 32'd0);
                @(negedge clk);
                set_req(int'(who), 1'b1, 1'b0, (who == 32'd0) ? 12'h010 : 12'hFFE, 32'd0);
            end
        end
        repeat (2) @(negedge clk);

        // Reset asserted during the third byte of a write
        poke(12'h100, 8'h00); poke(12'h101, 8'h00); poke(12'h102, 8'h5A); poke(12'h103, 8'h5B);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 12'h100, 32'hAABBCCDD);
        repeat (3) @(negedge clk);
        chk("mid_addr", {20'd0, mem_addr}, 32'h102);
        chk("mid_wdata", {24'd0, mem_wdata}, 32'hCC);
        acks0 = ack_total;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 12'h000, 32'd0);
        #1;
        chk("abort_ctrl", {27'd0, busy, grant, mem_we, m0_if.ack, m1_if.ack}, 32'd0);
        chk("abort_mem", {12'd0, mem_addr, mem_wdata}, 32'd0);
        chk("abort_rdata", m0_if.rdata, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_noack", 32'(ack_total - acks0), 32'd0);
        chk("abort_bytes", word_at(12'h100), 32'hAABB5A5B);
        transact(0, 1'b0, 12'h100, 32'd0, lat, wec, rd, g);
        chk("after_abort_lat", 32'(lat), 32'd6);
        chk("after_abort_rd", rd, 32'hAABB5A5B);

        repeat (2) @(negedge clk);
        chk("ack_exclusive", 32'(both_ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
